// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the ID/EX-side datapath and the pipeline
// sequencer. The master side (the sequencer) observes decode/execute status
// and drives the stage-register enable, flush and bubble controls.
interface pipe_ctrl_if;
  logic        id_vld;
  logic [2:0]  id_rs_vld;
  logic [11:0] id_rs_code;
  logic        ex_vld;
  logic        ex_load;
  logic [3:0]  ex_rd_code;
  logic        ex_mul_vld;
  logic        ex_swp_vld;
  logic        ex_ldm_vld;
  logic [4:0]  ex_ldm_cnt;
  logic        br_taken;
  logic        mem_busy;
  logic        irq_req;
  logic        if_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        exmem_en;
  logic        ex_busy;
  logic        irq_flag;

  modport master (
    input  id_vld, id_rs_vld, id_rs_code, ex_vld, ex_load, ex_rd_code,
    input  ex_mul_vld, ex_swp_vld, ex_ldm_vld, ex_ldm_cnt,
    input  br_taken, mem_busy, irq_req,
    output if_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
    output ex_busy, irq_flag
  );

  modport slave (
    output id_vld, id_rs_vld, id_rs_code, ex_vld, ex_load, ex_rd_code,
    output ex_mul_vld, ex_swp_vld, ex_ldm_vld, ex_ldm_cnt,
    output br_taken, mem_busy, irq_req,
    input  if_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
    input  ex_busy, irq_flag
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the ARMv4 core.
// Produces IF, IF/ID, ID/EX and EX/MEM enables plus flush/bubble controls.
// Handles load-use interlocks, multi-cycle EX ops (MUL/SWP/LDM), data-memory
// wait stalls, taken-branch flushes and IRQ tagging of one instruction.
// Optional build macro: PIPE_CTRL_PERF_EN adds stall_cnt / flush_cnt
// performance counters (CNT_W bits, wrapping).
module pipe_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int SWP_CYCLES = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_nxt_s;
  logic       ex_fresh_r;
  logic       irq_pend_r;

  logic [4:0] op_cyc_s;
  logic       ex_busy_s;
  logic       stall_s;
  logic       load_use_s;
  logic [2:0] rs_hit_s;

  logic       if_en_s;
  logic       ifid_en_s;
  logic       ifid_flush_s;
  logic       idex_en_s;
  logic       idex_bubble_s;
  logic       exmem_en_s;
  logic       ex_busy_out_s;
  logic       irq_flag_s;

  // EX occupancy of the instruction in EX; mul beats swp beats ldm, LDM count 0 means 1
  always_comb begin
    op_cyc_s = 5'd1;
    if (bus.ex_mul_vld) begin
      op_cyc_s = 5'(MUL_CYCLES);
    end else if (bus.ex_swp_vld) begin
      op_cyc_s = 5'(SWP_CYCLES);
    end else if (bus.ex_ldm_vld) begin
      if (bus.ex_ldm_cnt == 5'd0) begin
        op_cyc_s = 5'd1;
      end else begin
        op_cyc_s = bus.ex_ldm_cnt;
      end
    end else begin
      op_cyc_s = 5'd1;
    end
  end

  // Load-use detect: any valid source register of ID equals the load target in EX
  always_comb begin
    rs_hit_s[0] = bus.id_rs_vld[0] & (bus.id_rs_code[3:0]  == bus.ex_rd_code);
    rs_hit_s[1] = bus.id_rs_vld[1] & (bus.id_rs_code[7:4]  == bus.ex_rd_code);
    rs_hit_s[2] = bus.id_rs_vld[2] & (bus.id_rs_code[11:8] == bus.ex_rd_code);
    load_use_s  = bus.id_vld & bus.ex_vld & bus.ex_load & (|rs_hit_s);
  end

  // Multi-cycle sequencer: only a freshly entered op can start a count, and
  // the count advances only on cycles where memory is not waiting
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ex_busy_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (bus.ex_vld && ex_fresh_r && (op_cyc_s > 5'd1)) begin
          ex_busy_s   = 1'b1;
          cnt_nxt_s   = op_cyc_s - 5'd1;
          state_nxt_s = ST_MULTI;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MULTI: begin
        ex_busy_s = (cnt_r > 5'd1);
        if (!bus.mem_busy) begin
          cnt_nxt_s = cnt_r - 5'd1;
          if (cnt_r <= 5'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_MULTI;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // Stage controls by priority: stall, branch flush, load-use bubble, normal
  always_comb begin
    if_en_s       = 1'b0;
    ifid_en_s     = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b0;
    idex_bubble_s = 1'b0;
    exmem_en_s    = 1'b0;
    ex_busy_out_s = 1'b0;
    stall_s       = bus.mem_busy | ex_busy_s;
    if (rst) begin
      if_en_s = 1'b0;
    end else if (stall_s) begin
      ex_busy_out_s = ex_busy_s;
    end else if (bus.br_taken) begin
      if_en_s       = 1'b1;
      ifid_en_s     = 1'b1;
      ifid_flush_s  = 1'b1;
      idex_en_s     = 1'b1;
      idex_bubble_s = 1'b1;
      exmem_en_s    = 1'b1;
    end else if (load_use_s) begin
      idex_en_s     = 1'b1;
      idex_bubble_s = 1'b1;
      exmem_en_s    = 1'b1;
    end else begin
      if_en_s    = 1'b1;
      ifid_en_s  = 1'b1;
      idex_en_s  = 1'b1;
      exmem_en_s = 1'b1;
    end
    irq_flag_s = (irq_pend_r | bus.irq_req) & bus.id_vld & idex_en_s & ~idex_bubble_s;
  end

  // Sequencer state, fresh-entry marker and pending IRQ latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      cnt_r      <= 5'd0;
      ex_fresh_r <= 1'b0;
      irq_pend_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ex_fresh_r <= idex_en_s & ~idex_bubble_s & bus.id_vld;
      irq_pend_r <= (irq_pend_r | bus.irq_req) & ~irq_flag_s;
    end
  end

  assign bus.if_en       = if_en_s;
  assign bus.ifid_en     = ifid_en_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_en     = idex_en_s;
  assign bus.idex_bubble = idex_bubble_s;
  assign bus.exmem_en    = exmem_en_s;
  assign bus.ex_busy     = ex_busy_out_s;
  assign bus.irq_flag    = irq_flag_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Count fetch-stalled cycles and flush cycles, wrapping at full width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (!if_en_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ifid_flush_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule
